// File: rtl/circle_points_pkg.sv
// Shared types for the midpoint-circle point stream.
// State enum, symmetry index type and the eight-way offset table.
package circle_points_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    STEP,
    DONE
  } state_e;

  typedef logic [2:0] idx_t;

  typedef struct packed {
    logic swap;
    logic neg_a;
    logic neg_b;
  } sym_t;

  // (swap x/y, negate first, negate second) for indices 0..7
  localparam sym_t [0:7] SYM_TBL = '{
    '{1'b0, 1'b0, 1'b0},
    '{1'b0, 1'b0, 1'b1},
    '{1'b0, 1'b1, 1'b0},
    '{1'b0, 1'b1, 1'b1},
    '{1'b1, 1'b0, 1'b0},
    '{1'b1, 1'b0, 1'b1},
    '{1'b1, 1'b1, 1'b0},
    '{1'b1, 1'b1, 1'b1}
  };

endpackage

// File: rtl/circle_octant_sel.sv
// Maps (k, x, y) to a symmetric offset and its enable.
// CIRCLE_POINTS_DEDUP_EN also drops offsets already covered by a lower index.
module circle_octant_sel
  import circle_points_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  idx_t                    k_i,
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic        [7:0]       mask_i,
  output logic signed [WIDTH-1:0] ofs_a_o,
  output logic signed [WIDTH-1:0] ofs_b_o,
  output logic                    en_o
);

  function automatic logic [2*WIDTH-1:0] ofs(
    input idx_t                    k,
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] y
  );
    sym_t             s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    s = SYM_TBL[k];
    a = s.swap ? y : x;
    b = s.swap ? x : y;
    if (s.neg_a) a = -a;
    if (s.neg_b) b = -b;
    return {a, b};
  endfunction

  always_comb begin
    {ofs_a_o, ofs_b_o} = ofs(k_i, x_i, y_i);
    en_o = mask_i[k_i];
`ifdef CIRCLE_POINTS_DEDUP_EN
    for (int j = 0; j < 7; j++) begin
      if (j < int'(k_i) && mask_i[j] &&
          ofs(idx_t'(j), x_i, y_i) == {ofs_a_o, ofs_b_o})
        en_o = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/circle_points_stream.sv
// Midpoint-circle generator streaming up to eight symmetric points per step.
// Optional CIRCLE_POINTS_DEDUP_EN suppresses repeated offsets within a group.
module circle_points_stream
  import circle_points_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    _clock,
  input  logic                    _reset_n,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] center_x,
  input  logic signed [WIDTH-1:0] center_y,
  input  logic signed [WIDTH-1:0] radius,
  input  logic        [7:0]       oct_mask,
  output logic signed [WIDTH-1:0] _out0,
  output logic signed [WIDTH-1:0] _out1,
  output logic                    _valid,
  input  logic                    _ready,
  output logic                    _busy,
  output logic                    _done
);

  localparam int DW = WIDTH + 4;
  typedef logic signed [DW-1:0] dval_t;
  typedef logic signed [WIDTH-1:0] crd_t;

  localparam dval_t C0  = dval_t'(0);
  localparam dval_t C3  = dval_t'(3);
  localparam dval_t C6  = dval_t'(6);
  localparam dval_t C10 = dval_t'(10);
  localparam crd_t  ONE = crd_t'(1);

  state_e     state_q, state_d;
  idx_t       k_q, k_d;
  crd_t       x_q, x_d, y_q, y_d;
  crd_t       cx_q, cx_d, cy_q, cy_d;
  dval_t      d_q, d_d;
  logic [7:0] mask_q, mask_d;
  crd_t       out0_q, out0_d, out1_q, out1_d;
  logic       valid_q, valid_d;
  dval_t      xs, ys;
  crd_t       ofs_a, ofs_b;
  logic       sel_en;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    x_d     = x_q;
    y_d     = y_q;
    d_d     = d_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    mask_d  = mask_q;
    xs      = C0;
    ys      = C0;
    unique case (state_q)
      IDLE, DONE: begin
        if (_start) begin
          cx_d    = center_x;
          cy_d    = center_y;
          mask_d  = oct_mask;
          k_d     = '0;
          x_d     = '0;
          y_d     = radius;
          d_d     = C3 - (dval_t'(radius) <<< 1);
          state_d = radius[WIDTH-1] ? DONE : EMIT;
        end
      end
      EMIT: begin
        if (!valid_q || _ready) begin
          if (k_q == 3'd7) state_d = STEP;
          else k_d = k_q + 3'd1;
        end
      end
      STEP: begin
        if (y_q >= x_q) begin
          x_d = x_q + ONE;
          if (d_q > C0) y_d = y_q - ONE;
          xs = dval_t'(x_d);
          ys = dval_t'(y_d);
          // decision update uses the already-stepped x and y
          if (d_q > C0) d_d = d_q + ((xs - ys) <<< 2) + C10;
          else d_d = d_q + (xs <<< 2) + C6;
          k_d     = '0;
          state_d = EMIT;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  circle_octant_sel #(
    .WIDTH (WIDTH)
  ) u_sel (
    .k_i     (k_d),
    .x_i     (x_d),
    .y_i     (y_d),
    .mask_i  (mask_d),
    .ofs_a_o (ofs_a),
    .ofs_b_o (ofs_b),
    .en_o    (sel_en)
  );

  // outputs are registered from next-state so index 0 appears one edge after start
  always_comb begin
    out0_d  = cx_d + ofs_a;
    out1_d  = cy_d + ofs_b;
    valid_d = (state_d == EMIT) && sel_en;
  end

  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      d_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      mask_q  <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      x_q     <= x_d;
      y_q     <= y_d;
      d_q     <= d_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      mask_q  <= mask_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      valid_q <= valid_d;
    end
  end

  assign _out0  = out0_q;
  assign _out1  = out1_q;
  assign _valid = valid_q;
  assign _busy  = (state_q == EMIT) || (state_q == STEP);
  assign _done  = (state_q == DONE);

endmodule

// File: doc/circle_points_stream.md
# circle_points_stream

Parametrised midpoint-circle point generator: on `_start` it walks one octant of a circle of radius `radius` about (`center_x`, `center_y`). For each octant step it streams up to eight symmetric pixel coordinates on a ready/valid output. It is the next generation of the team's generator-style drawing blocks, adding a configurable width, output back-pressure, an octant mask for arcs, asynchronous reset, and optional duplicate suppression. It feeds the pixel-write front end of the frame-buffer path.

## Interface
- `WIDTH`, default 32: signed width of coordinates, radius and outputs.
- `_clock`  in  1  rising-edge clock.
- `_reset_n`  in  1  reset, active-low, asynchronous.
- `_start`  in  1  request a new circle; sampled only when not busy.
- `center_x`, `center_y`  in  WIDTH  signed centre; latched on an accepted start.
- `radius`  in  WIDTH  signed radius; latched on an accepted start.
- `oct_mask`  in  8  bit k enables symmetry index k; latched on an accepted start.
- `_out0`, `_out1`  out  WIDTH  signed x, y of the current point.
- `_valid`  out  1  `_out0`/`_out1` hold a point.
- `_ready`  in  1  consumer accepts the point when `_valid && _ready`.
- `_busy`  out  1  high from an accepted start until the DONE state.
- `_done`  out  1  level; high in the DONE state until the next accepted start.

## Operation
- **Start:** an accepted start (`_start` in IDLE or DONE) latches the inputs and sets x=0, y=radius, d=3−2·radius. `d` is held at WIDTH+4 bits signed. If radius<0, go straight to DONE.
- **Symmetry order:** index 0..7 gives offsets (x,y), (x,−y), (−x,y), (−x,−y), (y,x), (y,−x), (−y,x), (−y,−x). Each output is centre plus offset, truncated to WIDTH bits in two's complement (wraps, no saturation).
- **States:**
  - **IDLE:** waiting for a start.
  - **EMIT:** index k steps from 0 to 7.
    - If k is enabled, `_valid`=1 and the point is held until `_ready`. k advances on the handshake.
    - If k is disabled (or deduplicated), it uses one cycle with `_valid`=0.
    - After index 7 the block moves to STEP.
  - **STEP:** one cycle.
    - If !(y≥x), go to DONE.
    - Otherwise x←x+1. If d>0, then y←y−1 and d←d+4·(x'−y')+10; else d←d+4·x'+6, where x' and y' are the updated values. Then go to EMIT with k=0.
  - **DONE:** `_done`=1, `_busy`=0.
- **Loop check:** the condition is tested before the update, so the final emitted group may have x>y. This matches the golden Python model.
- **Start while busy:** ignored.
- **Reset at any time:** the FSM returns to IDLE. All outputs go to their reset values: `_out0`=`_out1`=0, `_valid`=0, `_busy`=0, `_done`=0.

## Timing
- An accepted start at edge n gives `_valid` with index 0 at n+1, if index 0 is enabled.
- With `_ready` held at 1 and all indices enabled, there is one point per cycle within a group and one bubble cycle per STEP.
- `_out0`, `_out1` and `_valid` are registered. They are stable while `_valid && !_ready`.
- `_done` rises one cycle after the failing STEP, or one cycle after the start when radius<0.

## Configuration
- `CIRCLE_POINTS_DEDUP_EN`:
  - **Defined:** index k is also suppressed when its offset equals the offset of any enabled lower index in the same group. The compare is on offsets, before masking of k itself. A suppressed index uses one cycle with `_valid`=0.
  - **Undefined:** every enabled index is emitted, duplicates included.

## Structure
- `circle_points_pkg` holds:
  - the state enum (IDLE, EMIT, STEP, DONE);
  - the 3-bit index typedef;
  - the sign/swap constant table for the eight offsets.
- Sub-module `circle_octant_sel` is combinational. It maps (k, x, y) to an offset and produces the duplicate-compare result when dedup is enabled.

## Test plan
- **r=2, centre (10,20), mask 0xFF, `_ready`=1:** 24 points. The first is (10,22) and the last is (9,18). `_done` rises afterwards and `_busy` falls.
- **r=0, centre (0,0), mask 0xFF:** 16 points, 8×(0,0) then (±1,∓1) variants. With `CIRCLE_POINTS_DEDUP_EN`: 5 points, (0,0),(1,−1),(1,1),(−1,−1),(−1,1).
- **Back-pressure:** r=2, `_ready` low for 3 cycles at the first `_valid`. (10,22) is held unchanged. The full 24-point sequence is otherwise identical.
- **Arc mask:** mask 0x01, r=2, centre (10,20). Exactly (10,22),(11,22),(12,21) are emitted. A `_start` pulse while busy is ignored.
- **Negative radius:** radius=−1 gives `_done`=1 the next cycle and no `_valid`.
- **Wrap and reset:** with WIDTH=8, centre (127,0), r=1, index 4 of the first group outputs (−128,0). Dropping `_reset_n` mid-stream clears `_valid`, `_busy` and the outputs immediately.
